// File: rtl/oct_cal_sequencer.sv
// OCT calibration initiator: parallel SAR searches for pull-up/pull-down codes, published via valid/ack.
// Codes held until code_ack; OCT_CAL_RECAL_EN adds a free-running periodic recalibration request.
module oct_cal_sequencer #(
   parameter int CODE_W  = 7,
   parameter int CLK_DIV = 4,
   parameter int SETTLE  = 8
`ifdef OCT_CAL_RECAL_EN
   , parameter int RECAL_PERIOD = 2**20
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cal_req,
   input  logic              rup_cmp,
   input  logic              rdn_cmp,
   input  logic              code_ack,
   output logic              terminationenable,
   output logic              terminationclock,
   output logic              cal_busy,
   output logic [CODE_W-1:0] rs_code_up,
   output logic [CODE_W-1:0] rs_code_dn,
   output logic              code_valid,
   output logic              cal_err
);

   localparam int WIN = 2 * CLK_DIV * SETTLE;
   localparam int DW  = $clog2(CLK_DIV + 1);
   localparam int WW  = $clog2(WIN);

   typedef enum logic [1:0] {S_IDLE, S_EN, S_STEP, S_DONE} state_t;

   state_t            r_state;
   logic              r_pending;
   logic              r_up_s1, r_up_s2, r_dn_s1, r_dn_s2;
   logic [DW-1:0]     r_div;
   logic [WW-1:0]     r_win;
   logic [CODE_W-1:0] r_trial_up, r_trial_dn, r_mask;
   logic              r_tenable, r_tclk, r_busy, r_valid, r_err;
   logic [CODE_W-1:0] r_code_up, r_code_dn;
   logic              w_recal_hit;
   logic              w_pend_set;

`ifdef OCT_CAL_RECAL_EN
   localparam int RW = (RECAL_PERIOD > 1) ? $clog2(RECAL_PERIOD) : 1;
   logic [RW-1:0] r_recal_cnt;

   assign w_recal_hit = (r_recal_cnt == RW'(RECAL_PERIOD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_recal_cnt <= '0;
      else if (w_recal_hit) r_recal_cnt <= '0;
      else                  r_recal_cnt <= r_recal_cnt + 1'b1;
   end
`else
   assign w_recal_hit = 1'b0;
`endif

   assign w_pend_set = w_recal_hit | ((r_state == S_DONE) & cal_req);

   // Comparator outputs come from the analog block and are asynchronous to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_up_s1 <= 1'b0;
         r_up_s2 <= 1'b0;
         r_dn_s1 <= 1'b0;
         r_dn_s2 <= 1'b0;
      end else begin
         r_up_s1 <= rup_cmp;
         r_up_s2 <= r_up_s1;
         r_dn_s1 <= rdn_cmp;
         r_dn_s2 <= r_dn_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pending  <= 1'b0;
         r_div      <= '0;
         r_win      <= '0;
         r_trial_up <= '0;
         r_trial_dn <= '0;
         r_mask     <= '0;
         r_tenable  <= 1'b0;
         r_tclk     <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_code_up  <= '0;
         r_code_dn  <= '0;
      end else begin
         r_pending <= r_pending | w_pend_set;
         case (r_state)
            S_IDLE: begin
               r_tclk <= 1'b0;
               r_div  <= '0;
               if (cal_req || r_pending) begin
                  r_state    <= S_EN;
                  r_pending  <= 1'b0;
                  r_tenable  <= 1'b1;
                  r_busy     <= 1'b1;
                  r_mask     <= {1'b1, {(CODE_W-1){1'b0}}};
                  r_trial_up <= {1'b1, {(CODE_W-1){1'b0}}};
                  r_trial_dn <= {1'b1, {(CODE_W-1){1'b0}}};
               end
            end
            S_EN: begin
               r_state <= S_STEP;
               r_div   <= '0;
               r_win   <= '0;
            end
            S_STEP: begin
               r_win <= r_win + 1'b1;
               if (r_div == DW'(CLK_DIV - 1)) begin
                  r_div  <= '0;
                  r_tclk <= ~r_tclk;
               end else begin
                  r_div <= r_div + 1'b1;
               end
               // End of settle window: resolve current bit, then trial the next lower one.
               if (r_win == WW'(WIN - 1)) begin
                  r_win      <= '0;
                  r_trial_up <= (r_up_s2 ? r_trial_up : (r_trial_up & ~r_mask)) | (r_mask >> 1);
                  r_trial_dn <= (r_dn_s2 ? r_trial_dn : (r_trial_dn & ~r_mask)) | (r_mask >> 1);
                  r_mask     <= r_mask >> 1;
                  if (r_mask[0]) begin
                     r_state   <= S_DONE;
                     r_tenable <= 1'b0;
                     r_tclk    <= 1'b0;
                     r_div     <= '0;
                  end
               end
            end
            S_DONE: begin
               if (!r_valid) begin
                  r_valid   <= 1'b1;
                  r_busy    <= 1'b0;
                  r_code_up <= r_trial_up;
                  r_code_dn <= r_trial_dn;
                  r_err     <= (r_trial_up == '0) | (r_trial_up == '1) |
                               (r_trial_dn == '0) | (r_trial_dn == '1);
               end else if (code_ack) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign terminationenable = r_tenable;
   assign terminationclock  = r_tclk;
   assign cal_busy          = r_busy;
   assign rs_code_up        = r_code_up;
   assign rs_code_dn        = r_code_dn;
   assign code_valid        = r_valid;
   assign cal_err           = r_err;

endmodule
